// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the serial boot loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int LEN_W          = HDR_BYTES * 8;

endpackage

// File: rtl/byte_assembler.sv
// Packs incoming bytes little-endian into a 32-bit word; flags the byte that completes it.
module byte_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [LANE_W-1:0] r_byte_cnt;
  logic [31:0]       r_lanes;
  logic [31:0]       w_merged;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_lanes    <= '0;
    end else if (i_byte_en) begin
      r_byte_cnt                  <= r_byte_cnt + LANE_W'(1);
      r_lanes[8*r_byte_cnt +: 8]  <= i_byte;
    end
  end

  // The completing byte is merged combinationally so the word can be registered on its own edge.
  always_comb begin
    w_merged = r_lanes;
    if (i_byte_en) w_merged[8*r_byte_cnt +: 8] = i_byte;
  end

  assign o_word       = w_merged;
  assign o_word_ready = i_byte_en && (r_byte_cnt == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/boot_loader.sv
// UART-fed RAM image loader: frames length + words, writes RAM, then releases the CPU.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              mem_busy,
  output logic              mem_enable,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  state_t              r_state, w_next_state;
  logic [7:0]          r_len_lo, w_len_lo;
  logic [LEN_W-1:0]    r_len, w_len;
  logic [LEN_W-1:0]    w_len_rx;
  logic                r_we, w_we;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [31:0]         r_data, w_data;
  logic [15:0]         r_words, w_words;
  logic                r_enable, r_hold, r_done, r_error;
  logic [31:0]         w_word;
  logic                w_word_ready;
  logic                w_byte_en;

  assign w_byte_en = rx_valid && (r_state == DATA);
  assign w_len_rx  = {rx_data, r_len_lo};

  byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_byte_en    (w_byte_en),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LEN_LO;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_len_lo     = r_len_lo;
    w_len        = r_len;
    w_we         = r_we;
    w_addr       = r_addr;
    w_data       = r_data;
    w_words      = r_words;
    case (r_state)
      LEN_LO: begin
        if (rx_valid) begin
          w_len_lo     = rx_data;
          w_next_state = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          w_len = w_len_rx;
          if (32'(w_len_rx) > 32'(MAX_WORDS)) w_next_state = ERROR;
          else if (w_len_rx == '0)             w_next_state = DONE;
          else                                 w_next_state = DATA;
        end
      end
      DATA: begin
        if (w_word_ready) begin
          w_we         = 1'b1;
          w_data       = w_word;
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        // An arriving byte while the word is still pending is an overrun; the write is abandoned.
        if (rx_valid) begin
          w_we         = 1'b0;
          w_next_state = ERROR;
        end else if (!mem_busy) begin
          w_we         = 1'b0;
          w_addr       = r_addr + ADDR_W'(BYTES_PER_WORD);
          w_words      = r_words + 16'd1;
          w_next_state = ((r_words + 16'd1) == r_len) ? DONE : DATA;
        end
      end
      DONE:    w_we = 1'b0;
      ERROR:   w_we = 1'b0;
      default: begin
        w_we         = 1'b0;
        w_next_state = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_lo <= '0;
      r_len    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_words  <= '0;
      r_enable <= 1'b1;
      r_hold   <= 1'b1;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_len_lo <= w_len_lo;
      r_len    <= w_len;
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_data   <= w_data;
      r_words  <= w_words;
      r_enable <= (w_next_state != DONE);
      r_hold   <= (w_next_state != DONE);
      r_done   <= (w_next_state == DONE);
      r_error  <= (w_next_state == ERROR);
    end
  end

  assign mem_enable   = r_enable;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_data     = r_data;
  assign cpu_hold     = r_hold;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_boot_loader.sv
// Directed and randomized checks of boot_loader against a queue-based frame model.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        mem_busy = 1'b0;
  logic        mem_enable, mem_we, cpu_hold, done, error;
  logic [11:0] mem_addr;
  logic [31:0] mem_data;
  logic [15:0] words_loaded;

  boot_loader #(.ADDR_W(12), .MAX_WORDS(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .mem_busy     (mem_busy),
    .mem_enable   (mem_enable),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_checks = 0;
  int          we_cycles = 0;
  logic [43:0] wr_q[$];
  logic [7:0]  pay_q[$];

  // RAM-side observer: every accepted write, in order.
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_we) we_cycles++;
      if (mem_we && !mem_busy) wr_q.push_back({mem_addr, mem_data});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [43:0] obs, input logic [43:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    mem_busy = 1'b0;
    reset    = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    wr_q.delete();
    we_cycles = 0;
    tick();
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_enable"}, 44'(mem_enable), 44'd1);
    check({pfx, "_we"},     44'(mem_we),     44'd0);
    check({pfx, "_addr"},   44'(mem_addr),   44'd0);
    check({pfx, "_data"},   44'(mem_data),   44'd0);
    check({pfx, "_hold"},   44'(cpu_hold),   44'd1);
    check({pfx, "_done"},   44'(done),       44'd0);
    check({pfx, "_error"},  44'(error),      44'd0);
    check({pfx, "_words"},  44'(words_loaded), 44'd0);
  endtask

  function automatic logic [43:0] model_write(input int i);
    logic [31:0] w;
    w = {pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]};
    return {12'(4 * i), w};
  endfunction

  // Sends a complete frame of n words from pay_q, random gaps and stalls, then checks the outcome.
  task automatic run_frame(input string tag, input int n, input int max_stall);
    logic [15:0] len;
    len = 16'(n);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_byte(pay_q[4*w+b]);
      end
      mem_busy = 1'b1;
      repeat ($urandom_range(0, max_stall)) tick();
      mem_busy = 1'b0;
      tick();
    end
    check({tag, "_nwr"}, 44'(wr_q.size()), 44'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], model_write(i));
    check({tag, "_done"},   44'(done),         44'd1);
    check({tag, "_words"},  44'(words_loaded), 44'(n));
    check({tag, "_hold"},   44'(cpu_hold),     44'd0);
    check({tag, "_enable"}, 44'(mem_enable),   44'd0);
    check({tag, "_error"},  44'(error),        44'd0);
  endtask

  initial begin
    repeat (2) tick();
    check_reset_values("rst");
    do_reset();

    // Two-word image from the plan
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame("two", 2, 0);
    check("two_w0_literal", wr_q.size() > 0 ? wr_q[0] : 44'h0, {12'h000, 32'h44332211});
    check("two_w1_literal", wr_q.size() > 1 ? wr_q[1] : 44'h0, {12'h004, 32'h88776655});

    // Empty image
    do_reset();
    send_byte(8'h00);
    check("zero_done_early", 44'(done), 44'd0);
    send_byte(8'h00);
    check("zero_done", 44'(done), 44'd1);
    check("zero_hold", 44'(cpu_hold), 44'd0);
    check("zero_enable", 44'(mem_enable), 44'd0);
    repeat (4) send_byte(8'($urandom));
    check("zero_no_we", 44'(we_cycles), 44'd0);
    check("zero_words", 44'(words_loaded), 44'd0);

    // Oversized length
    do_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    check("big_error", 44'(error), 44'd1);
    check("big_hold", 44'(cpu_hold), 44'd1);
    check("big_enable", 44'(mem_enable), 44'd1);
    repeat (6) send_byte(8'($urandom));
    check("big_no_we", 44'(we_cycles), 44'd0);
    check("big_sticky", 44'(error), 44'd1);
    check("big_done", 44'(done), 44'd0);

    // Largest legal length is accepted as data
    do_reset();
    send_byte(8'h00);
    send_byte(8'h04);
    check("max_error", 44'(error), 44'd0);
    repeat (4) send_byte(8'hA5);
    check("max_we", 44'(mem_we), 44'd1);
    check("max_data", 44'(mem_data), 44'hA5A5A5A5);

    // Stall: busy held for 5 cycles after the 4th byte
    do_reset();
    pay_q.delete();
    repeat (4) pay_q.push_back(8'($urandom));
    send_byte(8'h01);
    send_byte(8'h00);
    for (int b = 0; b < 3; b++) send_byte(pay_q[b]);
    mem_busy = 1'b1;
    send_byte(pay_q[3]);
    for (int c = 0; c < 6; c++) begin
      if (c == 5) mem_busy = 1'b0;
      check($sformatf("stall_we_c%0d", c), 44'(mem_we), 44'd1);
      check($sformatf("stall_wr_c%0d", c), {mem_addr, mem_data}, model_write(0));
      tick();
    end
    check("stall_we_off", 44'(mem_we), 44'd0);
    check("stall_nwr", 44'(wr_q.size()), 44'd1);
    check("stall_done", 44'(done), 44'd1);
    check("stall_words", 44'(words_loaded), 44'd1);

    // Overrun during a stalled write
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    repeat (4) send_byte(8'($urandom));
    mem_busy = 1'b1;
    check("ovr_we", 44'(mem_we), 44'd1);
    send_byte(8'($urandom));
    check("ovr_error", 44'(error), 44'd1);
    check("ovr_we_drop", 44'(mem_we), 44'd0);
    check("ovr_words", 44'(words_loaded), 44'd0);
    check("ovr_hold", 44'(cpu_hold), 44'd1);
    mem_busy = 1'b0;
    repeat (4) send_byte(8'($urandom));
    check("ovr_nwr", 44'(wr_q.size()), 44'd0);
    check("ovr_sticky", 44'(error), 44'd1);

    // Asynchronous reset while word 3 is pending
    do_reset();
    send_byte(8'h04);
    send_byte(8'h00);
    for (int w = 0; w < 2; w++) begin
      repeat (4) send_byte(8'($urandom));
      tick();
    end
    check("rmid_words2", 44'(words_loaded), 44'd2);
    mem_busy = 1'b1;
    repeat (4) send_byte(8'($urandom));
    check("rmid_we", 44'(mem_we), 44'd1);
    #2 reset = 1'b1;
    #1 check_reset_values("rmid");
    tick();
    reset    = 1'b0;
    mem_busy = 1'b0;
    wr_q.delete();
    we_cycles = 0;
    tick();
    pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame("rmid_new", 1, 2);
    check("rmid_new_literal", wr_q.size() > 0 ? wr_q[0] : 44'h0, {12'h000, 32'hDDCCBBAA});

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 6);
      pay_q.delete();
      repeat (4 * n) pay_q.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f), n, 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Serial program loader that sits directly upstream of the instruction/data RAM on the FPGA build. Consumes a byte stream from the UART receive port, assembles little-endian 32-bit words, and writes them to consecutive word-aligned RAM addresses through the FPGA-side memory mux. Holds the CPU in reset until the image is complete, then hands the memory port back to the request unit.

## Interface
Parameters:
- ADDR_W, 12: RAM byte-address width (matches RAM address port).
- MAX_WORDS, 1024: largest accepted image length in words; must satisfy MAX_WORDS*4 <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  single-cycle pulse; rx_data valid this cycle.
- mem_busy  in  1  RAM busy; a write is accepted on a cycle with mem_we=1 and mem_busy=0.
- mem_enable  out  1  1 = loader owns the RAM port (drives the FPGA memory mux select).
- mem_we  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM byte address, word-aligned.
- mem_data  out  32  RAM write data.
- cpu_hold  out  1  1 = CPU held in reset.
- done  out  1  image fully written.
- error  out  1  framing fault; sticky until reset.
- words_loaded  out  16  count of words accepted by RAM.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N*4 data bytes, least significant byte of each word first.
- States: LEN_LO -> LEN_HI -> DATA <-> WRITE -> DONE; any state except DONE -> ERROR on fault.
- LEN_LO: on rx_valid, latch N[7:0]; go to LEN_HI.
- LEN_HI: on rx_valid, latch N[15:8]. If N > MAX_WORDS -> ERROR. If N == 0 -> DONE. Else -> DATA.
- DATA: each rx_valid places the byte in lane byte_cnt (0..3) of the word register; byte_cnt increments mod 4. On the 4th byte -> WRITE.
- WRITE: mem_we=1 with mem_addr and mem_data stable until accepted (mem_busy=0). On acceptance: mem_addr += 4, words_loaded += 1; if words_loaded+1 == N -> DONE, else -> DATA.
- Overrun: rx_valid while in WRITE -> ERROR (byte discarded, no partial write).
- DONE: mem_enable=0, cpu_hold=0, done=1; further rx_valid ignored. Left only by reset.
- ERROR: mem_we=0, mem_enable=1, cpu_hold=1, error=1; rx ignored. Left only by reset.
- Address arithmetic: ADDR_W bits, low two bits always 0; no wrap is reachable because N <= MAX_WORDS.

## Timing
- Reset values: mem_enable=1, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, error=0, words_loaded=0, state LEN_LO, byte_cnt=0.
- Reset is asynchronous: asserting it mid-write drops mem_we the same instant and restarts framing from LEN_LO; partially written RAM contents are not cleared.
- All outputs registered. 4th data byte at cycle t -> mem_we=1 at t+1. If mem_busy=0 at t+1 -> mem_we=0 and addr/count updated at t+2.
- Last word accepted at cycle w -> done=1, cpu_hold=0, mem_enable=0 at w+1 (same edge).
- N==0: LEN_HI byte at t -> done=1 at t+1.
- mem_busy=1 in WRITE stalls indefinitely with outputs held.

## Structure
- Package boot_loader_pkg: state enum (LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR), frame header length constant (2 bytes), bytes-per-word constant (4).
- One sub-module: byte_assembler (byte_cnt counter, 32-bit lane register, word_ready pulse); FSM, address/count logic in boot_loader.

## Test plan
- Reset, send 02 00, 11 22 33 44, 55 66 77 88, mem_busy=0 -> writes 0x44332211 @0x000, 0x88776655 @0x004; done=1, words_loaded=2, cpu_hold=0, mem_enable=0.
- Send 00 00 -> done=1 one cycle after 2nd byte; mem_we never asserted.
- Send 01 04 (N=1025 > 1024) -> error=1, cpu_hold=1, no write; later bytes ignored.
- N=1, mem_busy held 1 for 5 cycles after 4th byte -> mem_we=1, addr 0x000, data stable for 6 cycles; accepted when busy drops, then done.
- N=2, rx_valid pulsed during WRITE while mem_busy=1 -> error=1, mem_we drops next cycle, words_loaded=0.
- Assert reset while in WRITE of word 3 -> all outputs to reset values asynchronously; fresh frame 01 00 AA BB CC DD then writes 0xDDCCBBAA @0x000.
